sram_master: RTL

- Initiator side of the external 256K x 16 asynchronous SRAM bus that the core and the Ram model share.
- Accepts 32-bit word read/write requests from the core over a valid/ready handshake.
- Splits each request into two 16-bit SRAM accesses and drives addr/data/wre/oute/hb_mask/lb_mask/chip_en with correct setup and strobe ordering.
- Returns read data and write acknowledgements on a one-cycle response pulse.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_master_if.sv | 26 ++
 rtl/sram_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus initiator (sram_master).
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Phase 0 carries the upper halfword (big-endian word layout)
    localparam logic PHASE_HI   = 1'b0;
    localparam logic PHASE_LO   = 1'b1;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_master_if.sv
// Core-side request/response handshake for sram_master.
interface sram_master_if #(
    parameter int ADDR_W = 18
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W:0]   req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    // master = the core issuing requests, slave = the SRAM initiator
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_master.sv
// Splits 32-bit core requests into two 16-bit asynchronous SRAM accesses.
// Optional macro SRAM_SKIP_MASKED_EN: skip write phases whose byte-enable pair is zero.
module sram_master
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clockFast,
    input  logic              reset,
    sram_master_if.slave      bus,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_stateNext;
    logic               r_phase;
    logic               w_phaseNext;
    logic               r_we;
    logic [ADDR_W-2:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [3:0]         r_cnt;
    logic [15:0]        r_hi;
    logic [31:0]        r_rdata;

    logic               w_accept;
    logic               w_lastWait;
    logic               w_skipHiReq;
    logic               w_skipLoReq;
    logic               w_skipLoCur;
    logic [1:0]         w_bePair;
    logic               w_drive;
    logic [15:0]        w_wdataHalf;

    // req_ready is gated by reset so it reads 0 for the whole reset period
    assign bus.req_ready = reset && (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;

    assign w_accept    = bus.req_valid && bus.req_ready;
    assign w_lastWait  = (r_cnt == 4'd1);
    assign addr        = {r_addr, r_phase};
    assign w_wdataHalf = (r_phase == PHASE_HI) ? r_wdata[31:16] : r_wdata[15:0];
    assign data        = w_drive ? w_wdataHalf : 16'hzzzz;

`ifdef SRAM_SKIP_MASKED_EN
    assign w_skipHiReq = bus.req_we && (bus.req_be[3:2] == 2'b00);
    assign w_skipLoReq = bus.req_we && (bus.req_be[1:0] == 2'b00);
    assign w_skipLoCur = r_we && (r_be[1:0] == 2'b00);
`else
    assign w_skipHiReq = 1'b0;
    assign w_skipLoReq = 1'b0;
    assign w_skipLoCur = 1'b0;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_phaseNext = r_phase;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_skipHiReq && w_skipLoReq) begin
                        w_stateNext = RESP;
                    end else begin
                        w_stateNext = SETUP;
                        w_phaseNext = w_skipHiReq ? PHASE_LO : PHASE_HI;
                    end
                end
            end
            SETUP:  w_stateNext = ACCESS;
            ACCESS: begin
                if (w_lastWait) begin
                    if ((r_phase == PHASE_HI) && !w_skipLoCur) begin
                        w_stateNext = SETUP;
                        w_phaseNext = PHASE_LO;
                    end else begin
                        w_stateNext = RESP;
                    end
                end
            end
            RESP:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Strobes derive only from registered state, so they are glitch-free and
    // wre/oute can never be low together.
    always_comb begin
        wre      = STROBE_OFF;
        oute     = STROBE_OFF;
        hb_mask  = STROBE_OFF;
        lb_mask  = STROBE_OFF;
        chip_en  = STROBE_OFF;
        w_drive  = 1'b0;
        w_bePair = (r_phase == PHASE_HI) ? r_be[3:2] : r_be[1:0];
        if ((r_state == SETUP) || (r_state == ACCESS)) begin
            chip_en = 1'b0;
            if (r_we) begin
                hb_mask = ~w_bePair[1];
                lb_mask = ~w_bePair[0];
                w_drive = 1'b1;
                if (r_state == ACCESS) begin
                    wre = 1'b0;
                end
            end else begin
                hb_mask = 1'b0;
                lb_mask = 1'b0;
                if (r_state == ACCESS) begin
                    oute = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clockFast or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_phase <= PHASE_HI;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_stateNext;
            r_phase <= w_phaseNext;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr[ADDR_W:2];
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
            if (r_state == SETUP) begin
                r_cnt <= WAIT_INIT;
            end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Read data is captured at the end of the final strobe cycle
            if ((r_state == ACCESS) && w_lastWait && !r_we) begin
                if (r_phase == PHASE_HI) begin
                    r_hi <= data;
                end else begin
                    r_rdata <= {r_hi, data};
                end
            end
        end
    end

endmodule
